mem_bus_ctrl: RTL
=================

// Module: mem_bus_ctrl
// PURPOSE
// Bus controller between the memory pipeline stage and the external 16-bit async SRAM/peripheral bus.
// Turns the stage's single-cycle read/write strobes into a timed bus cycle.
// - Counts wait states, honours a bus ready line and returns the full 16-bit word.
// - Stalls the pipeline via stall_o, which drives the stage enable low, until the access completes.
// - Byte order is big-endian: an even address selects the upper lane, an odd address the lower lane.
// PARAMETERS
// RD_WAIT  1    extra ACCESS cycles for reads (0..15)
// WR_WAIT  1    extra ACCESS cycles for writes (0..15)
// TIMEOUT  255  max cycles of bus_ready_i low after wait count expires; 0 disables timeout
// PORTS
// clk          in   1   clock, all state on rising edge
// rst_n        in   1   synchronous active-low reset
// req_addr     in   24  byte address from memory stage, stable while stall_o=1
// req_re       in   1   read request (stage mem_re_o)
// req_we       in   1   write request (stage mem_we_o)
// req_word     in   1   1 = 16-bit access, 0 = byte access
// req_wdata    in   16  write data; byte writes use [7:0]
// rdata_o      out  16  read word, registered, valid in DONE, held until next read
// stall_o      out  1   1 = hold pipeline (stage en = ~stall_o)
// err_o        out  1   one-cycle pulse in DONE when the access timed out
// bus_addr     out  23  word address = req_addr[23:1]
// bus_cs_n     out  1   chip select, active low
// bus_oe_n     out  1   output enable, active low (reads)
// bus_we_n     out  1   write enable, active low (writes)
// bus_be_n     out  2   lane enables, active low; [1]=upper/even byte, [0]=lower/odd byte
// bus_dout     out  16  write data driven to bus
// bus_dout_en  out  1   1 = drive bus_dout (writes only)
// bus_din      in   16  read data from bus
// bus_ready_i  in   1   1 = device ready; low extends ACCESS
// BEHAVIOUR
// - Reset: state=IDLE, counters=0, rdata_o=0, err_o=0, bus_cs_n=bus_oe_n=bus_we_n=1, bus_be_n=2'b11, bus_dout_en=0.
// - Bus outputs are registered; no combinational path from req_* to bus_*.
// - Reset mid-access aborts the access: the bus is released on the reset edge and no write completes.
// - stall_o = (req_re|req_we) & (state!=DONE); forced 1 while rst_n=0.
// - FSM IDLE -> ACCESS -> DONE -> IDLE.
// - IDLE: if req_we|req_re, latch the request and load the wait counter with WR_WAIT or RD_WAIT.
//   - Next state is ACCESS.
//   - If req_we and req_re are both set, the write wins and the read is dropped.
// - ACCESS: cs_n=0.
//   - Read: oe_n=0. Write: we_n=0, dout_en=1.
//   - Word access: be_n=00. Byte access: be_n=01 if addr[0]=0, 10 if addr[0]=1.
//   - Byte-write data is replicated: bus_dout={wdata[7:0],wdata[7:0]}. Word write: bus_dout=wdata.
//   - While the wait counter is nonzero it decrements each cycle.
//   - At zero with bus_ready_i=1: a read latches rdata_o<=bus_din, then next state is DONE.
//   - At zero with bus_ready_i=0: the timeout counter increments.
//   - Timeout counter reaches TIMEOUT (TIMEOUT!=0): next state DONE, rdata_o<=16'hFFFF for reads, err_o=1 in DONE.
// - DONE: all bus strobes deasserted, stall_o=0, so the stage samples rdata_o at the end of this cycle. Next state is always IDLE.
// - Back-to-back requests therefore have one dead IDLE cycle between bus cycles (bus turnaround).
// - Latency with bus_ready_i=1: stall asserted W+2 cycles, W = RD_WAIT or WR_WAIT; ACCESS lasts W+1 cycles.
// - rdata_o is unchanged by writes and by a read that does not complete.
// TESTING
// 1. RD_WAIT=2, byte read addr 24'h000101, bus_din=16'hA55A -> be_n=10, bus_addr=23'h000080, ACCESS 3 cycles, stall 4 cycles, rdata_o=A55A.
// 2. Word write addr 24'h000200, wdata=16'h1234 -> we_n=0, be_n=00, dout=1234, dout_en=1; oe_n stays 1.
// 3. Byte write addr 24'h000004, wdata=16'hXX7E -> be_n=01, bus_dout=16'h7E7E.
// 4. Read with bus_ready_i held low 5 cycles after wait count expires -> ACCESS extended 5 cycles; data latched on the ready cycle; err_o=0.
// 5. TIMEOUT=8, bus_ready_i stuck low -> DONE after 8 extra cycles, rdata_o=FFFF, err_o pulses 1 cycle.
// 6. rst_n low during a write ACCESS -> next edge cs_n=we_n=1, dout_en=0, state IDLE; re and we both set -> write only.

Source files
------------

// File: rtl/mem_bus_ctrl_if.sv
// rtl/mem_bus_ctrl_if.sv - request and external bus signals of the memory bus controller
interface mem_bus_ctrl_if;
    logic [23:0] req_addr;
    logic        req_re;
    logic        req_we;
    logic        req_word;
    logic [15:0] req_wdata;
    logic [15:0] rdata_o;
    logic        stall_o;
    logic        err_o;
    logic [22:0] bus_addr;
    logic        bus_cs_n;
    logic        bus_oe_n;
    logic        bus_we_n;
    logic [1:0]  bus_be_n;
    logic [15:0] bus_dout;
    logic        bus_dout_en;
    logic [15:0] bus_din;
    logic        bus_ready_i;

    // slave: the controller; master: pipeline stage plus the external device
    modport slave (
        input  req_addr, req_re, req_we, req_word, req_wdata, bus_din, bus_ready_i,
        output rdata_o, stall_o, err_o, bus_addr, bus_cs_n, bus_oe_n, bus_we_n,
        output bus_be_n, bus_dout, bus_dout_en
    );
    modport master (
        output req_addr, req_re, req_we, req_word, req_wdata, bus_din, bus_ready_i,
        input  rdata_o, stall_o, err_o, bus_addr, bus_cs_n, bus_oe_n, bus_we_n,
        input  bus_be_n, bus_dout, bus_dout_en
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - timed 16-bit async SRAM/peripheral bus cycle generator with stall and timeout
module mem_bus_ctrl #(
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_bus_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [3:0]  wcnt;
    logic [15:0] tcnt;
    logic        is_wr;
    logic [15:0] rdata_q;
    logic        err_q;
    logic        cs_n_q, oe_n_q, we_n_q, dout_en_q;
    logic [1:0]  be_n_q;
    logic [22:0] addr_q;
    logic [15:0] dout_q;
    logic        req_any, timed_out, finish;

    always_comb begin
        req_any   = bus.req_re | bus.req_we;
        timed_out = (TIMEOUT != 0) && (wcnt == 4'd0) && !bus.bus_ready_i && (tcnt == TO_LAST);
        finish    = (state == S_ACCESS) && (wcnt == 4'd0) && (bus.bus_ready_i || timed_out);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wcnt      <= 4'd0;
            tcnt      <= 16'd0;
            is_wr     <= 1'b0;
            rdata_q   <= 16'd0;
            err_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            dout_en_q <= 1'b0;
            be_n_q    <= 2'b11;
            addr_q    <= 23'd0;
            dout_q    <= 16'd0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_any) begin
                        // a simultaneous read is dropped in favour of the write
                        is_wr     <= bus.req_we;
                        wcnt      <= bus.req_we ? 4'(WR_WAIT) : 4'(RD_WAIT);
                        tcnt      <= 16'd0;
                        addr_q    <= bus.req_addr[23:1];
                        cs_n_q    <= 1'b0;
                        oe_n_q    <= bus.req_we;
                        we_n_q    <= ~bus.req_we;
                        dout_en_q <= bus.req_we;
                        be_n_q    <= bus.req_word ? 2'b00 : (bus.req_addr[0] ? 2'b10 : 2'b01);
                        dout_q    <= bus.req_word ? bus.req_wdata : {2{bus.req_wdata[7:0]}};
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (wcnt != 4'd0) begin
                        wcnt <= wcnt - 4'd1;
                    end else if (!bus.bus_ready_i) begin
                        tcnt <= tcnt + 16'd1;
                    end
                    if (finish) begin
                        if (!is_wr) begin
                            rdata_q <= bus.bus_ready_i ? bus.bus_din : 16'hFFFF;
                        end
                        err_q     <= timed_out;
                        cs_n_q    <= 1'b1;
                        oe_n_q    <= 1'b1;
                        we_n_q    <= 1'b1;
                        dout_en_q <= 1'b0;
                        be_n_q    <= 2'b11;
                        state     <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.stall_o     = !rst_n || (req_any && (state != S_DONE));
    assign bus.rdata_o     = rdata_q;
    assign bus.err_o       = err_q;
    assign bus.bus_addr    = addr_q;
    assign bus.bus_cs_n    = cs_n_q;
    assign bus.bus_oe_n    = oe_n_q;
    assign bus.bus_we_n    = we_n_q;
    assign bus.bus_be_n    = be_n_q;
    assign bus.bus_dout    = dout_q;
    assign bus.bus_dout_en = dout_en_q;
endmodule
